// File: rtl/noc_router_pkg.sv
// Shared types and the route-table lookup helper for the virtual-channel lookup stage.
package noc_router_pkg;

  typedef enum logic [1:0] {LK_IDLE, LK_WORM, LK_DROP} lookup_state_t;

  // Widest flattened table / output set the helper can address.
  localparam int unsigned LK_MAX_TABLE   = 1024;
  localparam int unsigned LK_MAX_OUTPUTS = 64;

  // Entry d of a flattened table; destinations outside the table read as route 0.
  function automatic logic [LK_MAX_OUTPUTS-1:0] route_entry(
    input logic [LK_MAX_TABLE-1:0] tbl,
    input int unsigned             dest,
    input int unsigned             dests,
    input int unsigned             outputs
  );
    logic [LK_MAX_OUTPUTS-1:0] r;
    r = '0;
    if (dest < dests) begin
      r = LK_MAX_OUTPUTS'(tbl >> (dest * outputs));
      r = r & ~({LK_MAX_OUTPUTS{1'b1}} << outputs);
    end
    return r;
  endfunction

endpackage

// File: rtl/noc_router_lookup_skid.sv
// Two-entry output skid buffer for one channel: registered in_ready, all-or-nothing multicast pop.
module noc_router_lookup_skid #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned OUTPUTS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [FLIT_WIDTH-1:0] push_flit,
  input  logic                  push_last,
  input  logic [OUTPUTS-1:0]    push_sel,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_last,
  output logic [OUTPUTS-1:0]    out_valid,
  input  logic [OUTPUTS-1:0]    out_ready
);

  logic [1:0]            count_q, count_d;
  logic [FLIT_WIDTH-1:0] head_flit_q, head_flit_d, tail_flit_q, tail_flit_d;
  logic                  head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic [OUTPUTS-1:0]    head_sel_q, head_sel_d, tail_sel_q, tail_sel_d;
  logic                  ready_q, ready_d;
  logic                  nonempty, pop;

  assign nonempty = (count_q != 2'd0);
  // The head leaves only once every selected output is ready at the same time.
  assign pop      = nonempty && ((out_ready & head_sel_q) == head_sel_q);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    count_d     = count_q;
    head_flit_d = head_flit_q;
    head_last_d = head_last_q;
    head_sel_d  = head_sel_q;
    tail_flit_d = tail_flit_q;
    tail_last_d = tail_last_q;
    tail_sel_d  = tail_sel_q;
    if (pop) begin
      if (count_q == 2'd2) begin
        head_flit_d = tail_flit_q;
        head_last_d = tail_last_q;
        head_sel_d  = tail_sel_q;
      end
      count_d = count_q - 2'd1;
    end
    if (push) begin
      if (count_d == 2'd0) begin
        head_flit_d = push_flit;
        head_last_d = push_last;
        head_sel_d  = push_sel;
      end else begin
        tail_flit_d = push_flit;
        tail_last_d = push_last;
        tail_sel_d  = push_sel;
      end
      count_d = count_d + 2'd1;
    end
    ready_d = (count_d != 2'd2);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 2'd0;
      ready_q     <= 1'b1;
      // NOTE: the entries are reset too, because out_flit must read 0 out of reset.
      head_flit_q <= '0;
      head_last_q <= 1'b0;
      head_sel_q  <= '0;
      tail_flit_q <= '0;
      tail_last_q <= 1'b0;
      tail_sel_q  <= '0;
    end else begin
      count_q     <= count_d;
      ready_q     <= ready_d;
      head_flit_q <= head_flit_d;
      head_last_q <= head_last_d;
      head_sel_q  <= head_sel_d;
      tail_flit_q <= tail_flit_d;
      tail_last_q <= tail_last_d;
      tail_sel_q  <= tail_sel_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_flit  = head_flit_q;
  assign out_last  = head_last_q & nonempty;
  assign out_valid = head_sel_q & {OUTPUTS{nonempty}};

endmodule

// File: rtl/noc_router_lookup_vchannel.sv
// Per-channel route lookup with worm hold, unroutable-worm drop and multicast skid output.
// Define NOC_LOOKUP_TABLE_WR_EN to make the route table writable through cfg_* ports.
module noc_router_lookup_vchannel
  import noc_router_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned DEST_WIDTH = 5,
  parameter int unsigned DESTS      = 1,
  parameter int unsigned OUTPUTS    = 1,
  parameter int unsigned CHANNELS   = 1,
  parameter logic [DESTS*OUTPUTS-1:0] ROUTES = '0
) (
  input  logic                           clk,
  input  logic                           rst,
`ifdef NOC_LOOKUP_TABLE_WR_EN
  input  logic                           cfg_we,
  input  logic [DEST_WIDTH-1:0]          cfg_dest,
  input  logic [OUTPUTS-1:0]             cfg_route,
`endif
  input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]            in_last,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [CHANNELS*FLIT_WIDTH-1:0] out_flit,
  output logic [CHANNELS-1:0]            out_last,
  output logic [CHANNELS*OUTPUTS-1:0]    out_valid,
  input  logic [CHANNELS*OUTPUTS-1:0]    out_ready,
  output logic [CHANNELS-1:0]            drop
);

  logic [DESTS*OUTPUTS-1:0] route_table;

`ifdef NOC_LOOKUP_TABLE_WR_EN
  logic [DESTS*OUTPUTS-1:0] table_q, table_d;

  always_comb begin
    table_d = table_q;
    for (int unsigned d = 0; d < DESTS; d++) begin
      if (cfg_we && (32'(cfg_dest) == d)) table_d[d*OUTPUTS +: OUTPUTS] = cfg_route;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) table_q <= ROUTES;
    else     table_q <= table_d;
  end

  // Lookups read the registered table, so a same-cycle write is seen by the next header only.
  assign route_table = table_q;
`else
  assign route_table = ROUTES;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    lookup_state_t         state_q, state_d;
    logic [OUTPUTS-1:0]    worm_q, worm_d;
    logic                  drop_q, drop_d;
    logic [OUTPUTS-1:0]    route, push_sel;
    logic [DEST_WIDTH-1:0] dest;
    logic                  push, hs, ready;

    assign dest  = in_flit[c*FLIT_WIDTH + FLIT_WIDTH-1 -: DEST_WIDTH];
    assign route = OUTPUTS'(route_entry(LK_MAX_TABLE'(route_table), 32'(dest), DESTS, OUTPUTS));
    assign hs    = in_valid[c] & ready;

    always_comb begin
      state_d  = state_q;
      worm_d   = worm_q;
      drop_d   = 1'b0;
      push     = 1'b0;
      push_sel = '0;
      case (state_q)
        LK_IDLE: if (hs) begin
          if (route != '0) begin
            push     = 1'b1;
            push_sel = route;
            if (!in_last[c]) begin
              state_d = LK_WORM;
              worm_d  = route;
            end
          end else if (in_last[c]) begin
            drop_d = 1'b1;
          end else begin
            state_d = LK_DROP;
          end
        end
        LK_WORM: if (hs) begin
          push     = 1'b1;
          push_sel = worm_q;
          if (in_last[c]) state_d = LK_IDLE;
        end
        LK_DROP: if (hs && in_last[c]) begin
          drop_d  = 1'b1;
          state_d = LK_IDLE;
        end
        default: state_d = LK_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= LK_IDLE;
        worm_q  <= '0;
        drop_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        worm_q  <= worm_d;
        drop_q  <= drop_d;
      end
    end

    noc_router_lookup_skid #(
      .FLIT_WIDTH (FLIT_WIDTH),
      .OUTPUTS    (OUTPUTS)
    ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_flit (in_flit[c*FLIT_WIDTH +: FLIT_WIDTH]),
      .push_last (in_last[c]),
      .push_sel  (push_sel),
      .in_ready  (ready),
      .out_flit  (out_flit[c*FLIT_WIDTH +: FLIT_WIDTH]),
      .out_last  (out_last[c]),
      .out_valid (out_valid[c*OUTPUTS +: OUTPUTS]),
      .out_ready (out_ready[c*OUTPUTS +: OUTPUTS])
    );

    assign in_ready[c] = ready;
    assign drop[c]     = drop_q;
  end

endmodule

// File: tb/tb_noc_router_lookup_vchannel.sv
// Bench for noc_router_lookup_vchannel: lookup vector table, directed corner sequences and a
// randomized run against a worm-level scoreboard model (cfg writes exercised when NOC_LOOKUP_TABLE_WR_EN is set).
module tb_noc_router_lookup_vchannel;

  localparam int FW = 32;
  localparam int DW = 5;
  localparam int DESTS = 4;
  localparam int OUTS = 4;
  localparam int CH = 2;
  // dest0 = 0001, dest1 = 0010, dest2 = 0101 (multicast), dest3 = 0000 (unroutable)
  localparam logic [DESTS*OUTS-1:0] ROUTES = 16'h0521;

  typedef struct { logic [FW-1:0] flit; logic last; } tx_t;
  typedef struct { logic [FW-1:0] flit; logic last; logic [OUTS-1:0] sel; } ob_t;
  typedef struct { int ch; logic [DW-1:0] dest; logic [OUTS-1:0] exp_sel; logic exp_drop; } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_we;
  logic [DW-1:0]        cfg_dest;
  logic [OUTS-1:0]      cfg_route;
  logic [CH*FW-1:0]     in_flit;
  logic [CH-1:0]        in_last, in_valid, in_ready, out_last, drop;
  logic [CH*FW-1:0]     out_flit;
  logic [CH*OUTS-1:0]   out_valid, out_ready;

  noc_router_lookup_vchannel #(
    .FLIT_WIDTH (FW), .DEST_WIDTH (DW), .DESTS (DESTS),
    .OUTPUTS (OUTS), .CHANNELS (CH), .ROUTES (ROUTES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef NOC_LOOKUP_TABLE_WR_EN
    .cfg_we    (cfg_we),
    .cfg_dest  (cfg_dest),
    .cfg_route (cfg_route),
`endif
    .in_flit   (in_flit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus queues and the worm-level reference model.
  tx_t             tx_q [CH][$];
  ob_t             mq [CH][$];
  logic [OUTS-1:0] m_tbl [DESTS];
  bit              m_in_worm [CH];
  logic [OUTS-1:0] m_worm_route [CH];
  logic            m_exp_drop [CH];
  bit              hold [CH];

  // Values sampled by the most recent step().
  logic [OUTS-1:0] s_valid [CH];
  logic [FW-1:0]   s_flit [CH];
  logic            s_last [CH], s_drop [CH], s_ready [CH], s_hs [CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OUTS-1:0] route_of(input logic [DW-1:0] d);
    if (d < DW'(DESTS)) return m_tbl[d[1:0]];
    return '0;
  endfunction

  function automatic logic [FW-1:0] mkf(input logic [DW-1:0] d);
    logic [FW-DW-1:0] payload;
    payload = (FW-DW)'($urandom);
    return {d, payload};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mq[c].delete();
      m_in_worm[c]    = 0;
      m_worm_route[c] = '0;
      m_exp_drop[c]   = 1'b0;
    end
    m_tbl[0] = 4'b0001;
    m_tbl[1] = 4'b0010;
    m_tbl[2] = 4'b0101;
    m_tbl[3] = 4'b0000;
  endtask

  task automatic push_tx(input int c, input logic [DW-1:0] d, input logic l);
    tx_t t;
    t.flit = mkf(d);
    t.last = l;
    tx_q[c].push_back(t);
  endtask

  task automatic drive();
    for (int c = 0; c < CH; c++) begin
      if (tx_q[c].size() > 0 && !hold[c]) begin
        in_valid[c]           = 1'b1;
        in_flit[c*FW +: FW]   = tx_q[c][0].flit;
        in_last[c]            = tx_q[c][0].last;
      end else begin
        in_valid[c]           = 1'b0;
        in_flit[c*FW +: FW]   = $urandom;
        in_last[c]            = 1'(($urandom));
      end
    end
  endtask

  // One clock: sample and compare at negedge, advance the model, then drive just after posedge.
  task automatic step();
    logic [OUTS-1:0] orc, ev;
    logic [FW-1:0]   f;
    logic            l, hs;
    logic [OUTS-1:0] r;
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      s_valid[c] = out_valid[c*OUTS +: OUTS];
      s_flit[c]  = out_flit[c*FW +: FW];
      s_last[c]  = out_last[c];
      s_drop[c]  = drop[c];
      s_ready[c] = in_ready[c];
      ev = (mq[c].size() > 0) ? mq[c][0].sel : '0;
      check($sformatf("out_valid_ch%0d", c), 64'(s_valid[c]), 64'(ev));
      if (mq[c].size() > 0) begin
        check($sformatf("out_flit_ch%0d", c), 64'(s_flit[c]), 64'(mq[c][0].flit));
        check($sformatf("out_last_ch%0d", c), 64'(s_last[c]), 64'(mq[c][0].last));
      end
      check($sformatf("in_ready_ch%0d", c), 64'(s_ready[c]), 64'(mq[c].size() < 2));
      check($sformatf("drop_ch%0d", c), 64'(s_drop[c]), 64'(m_exp_drop[c]));
    end
    for (int c = 0; c < CH; c++) begin
      s_hs[c] = 1'b0;
      if (!rst) begin
        m_exp_drop[c] = 1'b0;
        orc = out_ready[c*OUTS +: OUTS];
        hs  = in_valid[c] && (mq[c].size() < 2);
        if (mq[c].size() > 0 && ((orc & mq[c][0].sel) == mq[c][0].sel)) void'(mq[c].pop_front());
        if (hs) begin
          s_hs[c] = 1'b1;
          f = in_flit[c*FW +: FW];
          l = in_last[c];
          void'(tx_q[c].pop_front());
          if (!m_in_worm[c]) begin
            r = route_of(f[FW-1 -: DW]);
            if (r != '0) mq[c].push_back('{flit: f, last: l, sel: r});
            else if (l) m_exp_drop[c] = 1'b1;
            if (!l) begin
              m_in_worm[c]    = 1;
              m_worm_route[c] = r;
            end
          end else begin
            if (m_worm_route[c] != '0) mq[c].push_back('{flit: f, last: l, sel: m_worm_route[c]});
            else if (l) m_exp_drop[c] = 1'b1;
            if (l) m_in_worm[c] = 0;
          end
        end
      end
    end
    if (rst) model_reset();
`ifdef NOC_LOOKUP_TABLE_WR_EN
    else if (cfg_we && cfg_dest < DW'(DESTS)) m_tbl[cfg_dest[1:0]] = cfg_route;
`endif
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit busy();
    for (int c = 0; c < CH; c++) if (tx_q[c].size() > 0 || mq[c].size() > 0) return 1;
    return 0;
  endfunction

  task automatic drain();
    int n = 0;
    out_ready = '1;
    for (int c = 0; c < CH; c++) hold[c] = 0;
    drive();
    while (busy() && n < 60) begin
      step();
      n++;
    end
    check("drain_idle", 64'(busy()), 64'd0);
  endtask

  vec_t            vecs [9];
  logic [OUTS-1:0] hist [12];
  logic            lh [12];
  logic [FW-1:0]   hdr_flit, f1_flit;

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_dest = '0; cfg_route = '0;
    in_valid = '0; in_last = '0; in_flit = '0; out_ready = '1;
    for (int c = 0; c < CH; c++) hold[c] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_flit", 64'(out_flit), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_drop", 64'(drop), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'(2'b11));

    // Lookup vectors: single-flit worms, one at a time
    vecs[0] = '{0, 5'd0,  4'b0001, 1'b0};
    vecs[1] = '{0, 5'd1,  4'b0010, 1'b0};
    vecs[2] = '{0, 5'd2,  4'b0101, 1'b0};
    vecs[3] = '{0, 5'd3,  4'b0000, 1'b1};
    vecs[4] = '{0, 5'd4,  4'b0000, 1'b1};
    vecs[5] = '{0, 5'd31, 4'b0000, 1'b1};
    vecs[6] = '{1, 5'd1,  4'b0010, 1'b0};
    vecs[7] = '{1, 5'd2,  4'b0101, 1'b0};
    vecs[8] = '{1, 5'd5,  4'b0000, 1'b1};
    for (int i = 0; i < 9; i++) begin
      push_tx(vecs[i].ch, vecs[i].dest, 1'b1);
      drive();
      step();
      step();
      check($sformatf("vec%0d_sel", i), 64'(s_valid[vecs[i].ch]), 64'(vecs[i].exp_sel));
      check($sformatf("vec%0d_drop", i), 64'(s_drop[vecs[i].ch]), 64'(vecs[i].exp_drop));
    end

    // 3-flit worm to dest 1; body flits carry an unroutable dest that must be ignored
    push_tx(0, 5'd1, 1'b0); push_tx(0, 5'd3, 1'b0); push_tx(0, 5'd3, 1'b1);
    drive();
    for (int k = 0; k < 6; k++) begin step(); hist[k] = s_valid[0]; lh[k] = s_last[0]; end
    for (int k = 0; k < 6; k++)
      check($sformatf("worm3_valid_k%0d", k), 64'(hist[k]), (k >= 1 && k <= 3) ? 64'(4'b0010) : 64'd0);
    check("worm3_last_k2", 64'(lh[2]), 64'd0);
    check("worm3_last_k3", 64'(lh[3]), 64'd1);

    // 4-flit unroutable worm: drained, drop after the 4th handshake
    push_tx(0, 5'd3, 1'b0); push_tx(0, 5'd1, 1'b0); push_tx(0, 5'd1, 1'b0); push_tx(0, 5'd1, 1'b1);
    drive();
    for (int k = 0; k < 6; k++) begin
      step();
      if (k < 4) check($sformatf("dropworm_ready_k%0d", k), 64'(s_ready[0]), 64'd1);
      check($sformatf("dropworm_valid_k%0d", k), 64'(s_valid[0]), 64'd0);
      check($sformatf("dropworm_drop_k%0d", k), 64'(s_drop[0]), 64'(k == 4));
    end

    // Multicast 0101 with only output 0 ready for three cycles
    push_tx(0, 5'd2, 1'b0); push_tx(0, 5'd0, 1'b0); push_tx(0, 5'd0, 1'b1);
    hdr_flit = tx_q[0][0].flit;
    f1_flit  = tx_q[0][1].flit;
    drive();
    for (int k = 0; k < 8; k++) begin
      out_ready[3:0] = (k < 4) ? 4'b0001 : 4'b0101;
      step();
      if (k >= 1 && k <= 4) begin
        check($sformatf("mcast_valid_k%0d", k), 64'(s_valid[0]), 64'(4'b0101));
        check($sformatf("mcast_hold_k%0d", k), 64'(s_flit[0]), 64'(hdr_flit));
      end
      if (k <= 5) check($sformatf("mcast_ready_k%0d", k), 64'(s_ready[0]), 64'(k < 2 || k == 5));
      if (k == 5) check("mcast_next_flit", 64'(s_flit[0]), 64'(f1_flit));
    end
    drain();

    // ch0 stalled while ch1 streams 8 flits at full rate
    out_ready = {4'b1111, 4'b0000};
    push_tx(0, 5'd1, 1'b0); push_tx(0, 5'd1, 1'b0); push_tx(0, 5'd1, 1'b0); push_tx(0, 5'd1, 1'b1);
    for (int i = 0; i < 8; i++) push_tx(1, (i == 0) ? 5'd1 : 5'd3, i == 7);
    drive();
    for (int k = 0; k < 10; k++) begin
      step();
      if (k < 8) check($sformatf("stream_hs_k%0d", k), 64'(s_hs[1]), 64'd1);
      check($sformatf("stream_valid_k%0d", k), 64'(s_valid[1]), (k >= 1 && k <= 8) ? 64'(4'b0010) : 64'd0);
      if (k >= 2) check($sformatf("stall_ready_k%0d", k), 64'(s_ready[0]), 64'd0);
    end
    drain();

    // Back-to-back single-flit worms, each routed on its own header
    push_tx(0, 5'd1, 1'b1); push_tx(0, 5'd2, 1'b1); push_tx(0, 5'd0, 1'b1);
    drive();
    for (int k = 0; k < 5; k++) begin step(); hist[k] = s_valid[0]; end
    check("b2b_k1", 64'(hist[1]), 64'(4'b0010));
    check("b2b_k2", 64'(hist[2]), 64'(4'b0101));
    check("b2b_k3", 64'(hist[3]), 64'(4'b0001));

`ifdef NOC_LOOKUP_TABLE_WR_EN
    // Table write racing a header to the same dest: header sees the old entry
    push_tx(0, 5'd1, 1'b1);
    drive();
    cfg_we = 1'b1; cfg_dest = 5'd1; cfg_route = 4'b1000;
    step();
    cfg_we = 1'b0;
    push_tx(0, 5'd1, 1'b1);
    drive();
    step();
    check("cfg_old_route", 64'(s_valid[0]), 64'(4'b0010));
    step();
    check("cfg_new_route", 64'(s_valid[0]), 64'(4'b1000));
    // Out-of-range write is ignored
    cfg_we = 1'b1; cfg_dest = 5'd4; cfg_route = 4'b1111;
    step();
    cfg_we = 1'b0;
    push_tx(0, 5'd4, 1'b1);
    drive();
    step();
    step();
    check("cfg_oob_drop", 64'(s_drop[0]), 64'd1);
    drain();
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < CH; c++) begin
        if (tx_q[c].size() < 2) push_tx(c, DW'($urandom_range(0, 5)), $urandom_range(0, 2) == 0);
        hold[c] = ($urandom_range(0, 3) == 0);
      end
      for (int b = 0; b < CH*OUTS; b++) out_ready[b] = ($urandom_range(0, 3) != 0);
`ifdef NOC_LOOKUP_TABLE_WR_EN
      cfg_we    = ($urandom_range(0, 19) == 0);
      cfg_dest  = DW'($urandom_range(0, 5));
      cfg_route = OUTS'($urandom);
`endif
      drive();
      step();
    end
    cfg_we = 1'b0;
    drain();

    // Reset in the middle of a forwarded worm and a dropped worm
    push_tx(0, 5'd1, 1'b0); push_tx(0, 5'd1, 1'b0); push_tx(1, 5'd3, 1'b0);
    out_ready = '0;
    drive();
    step();
    step();
    for (int c = 0; c < CH; c++) tx_q[c].delete();
    drive();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = '1;
    step();
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_drop", 64'(drop), 64'd0);
    push_tx(0, 5'd2, 1'b1); push_tx(1, 5'd1, 1'b1);
    drive();
    step();
    step();
    check("midrst_ch0_route", 64'(s_valid[0]), 64'(4'b0101));
    check("midrst_ch1_route", 64'(s_valid[1]), 64'(4'b0010));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
